// File: rtl/id_hazard_stage.sv
// id_hazard_stage: RV32I decode stage with a write-back scoreboard hazard unit
// and a registered ID/EX output entry.
// Optional feature macro: ID_FORWARD_EN (load-use hazards only; EX/MEM forwarding assumed).
module id_hazard_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REGW     = 5,
  parameter int unsigned WB_DEPTH = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic            out_func7b5,
  output logic [REGW-1:0] out_rs1,
  output logic [REGW-1:0] out_rs2,
  output logic [REGW-1:0] out_rd,
  output logic            out_regwrite,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic            stall
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]            opcode;
  logic                  use_rs1, use_rs2, wr_rd, dec_illegal;
  logic [31:0]           imm32;
  logic [REGW-1:0]       dec_rs1, dec_rs2, dec_rd;
  logic                  dec_rw;
  logic [1:0][REGW-1:0]  rs_use;
  logic                  hit, hazard, accept, xfer;

  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_pc_q, out_imm_q;
  logic [6:0]            out_opcode_q;
  logic [2:0]            out_func3_q;
  logic                  out_f7_q, out_rw_q, out_ill_q;
  logic [REGW-1:0]       out_rs1_q, out_rs2_q, out_rd_q;

  logic [WB_DEPTH-1:0]            sb_v_q;
  logic [WB_DEPTH-1:0][REGW-1:0]  sb_rd_q;

`ifdef ID_FORWARD_EN
  logic                  dec_is_load;
  logic                  out_ld_q;
  logic [WB_DEPTH-1:0]   sb_ld_q;
  assign dec_is_load = (opcode == OPC_LOAD);
`endif

  assign opcode = in_instr[6:0];

  // Operand use, rd write and immediate format per opcode
  always_comb begin
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    wr_rd       = 1'b0;
    dec_illegal = 1'b0;
    imm32       = 32'd0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_rd   = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        wr_rd = 1'b1;
        imm32 = {in_instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        wr_rd = 1'b1;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_rs1 = use_rs1 ? REGW'(in_instr[19:15]) : '0;
  assign dec_rs2 = use_rs2 ? REGW'(in_instr[24:20]) : '0;
  assign dec_rw  = wr_rd && (in_instr[11:7] != 5'd0);
  assign dec_rd  = dec_rw ? REGW'(in_instr[11:7]) : '0;
  assign rs_use  = {dec_rs2, dec_rs1};

  // Match used source registers against the output entry and in-flight writes
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (rs_use[i] != '0) begin
`ifdef ID_FORWARD_EN
        if (out_valid_q && out_rw_q && out_ld_q && (out_rd_q == rs_use[i])) hit = 1'b1;
        if (sb_v_q[0] && sb_ld_q[0] && (sb_rd_q[0] == rs_use[i])) hit = 1'b1;
`else
        if (out_valid_q && out_rw_q && (out_rd_q == rs_use[i])) hit = 1'b1;
        for (int unsigned k = 0; k < WB_DEPTH; k++) begin
          if (sb_v_q[k] && (sb_rd_q[k] == rs_use[i])) hit = 1'b1;
        end
`endif
      end
    end
  end

  assign hazard   = in_valid && hit;
  assign stall    = hazard;
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready && !flush;

  // Output-entry occupancy: flush kills, accept fills, transfer without refill leaves a bubble
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // ID/EX register; payload only changes when a new instruction is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_opcode_q <= '0;
      out_func3_q  <= '0;
      out_f7_q     <= 1'b0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_rd_q     <= '0;
      out_rw_q     <= 1'b0;
      out_imm_q    <= '0;
      out_ill_q    <= 1'b0;
`ifdef ID_FORWARD_EN
      out_ld_q     <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_pc_q     <= in_pc;
        out_opcode_q <= opcode;
        out_func3_q  <= in_instr[14:12];
        out_f7_q     <= in_instr[30];
        out_rs1_q    <= dec_rs1;
        out_rs2_q    <= dec_rs2;
        out_rd_q     <= dec_rd;
        out_rw_q     <= dec_rw;
        out_imm_q    <= XLEN'($signed(imm32));
        out_ill_q    <= dec_illegal;
`ifdef ID_FORWARD_EN
        out_ld_q     <= dec_is_load;
`endif
      end
    end
  end

  // Scoreboard shift line: slot 0 takes the transferring writer, older slots age out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_v_q  <= '0;
      sb_rd_q <= '0;
`ifdef ID_FORWARD_EN
      sb_ld_q <= '0;
`endif
    end else begin
      sb_v_q[0]  <= xfer && out_rw_q;
      sb_rd_q[0] <= out_rd_q;
`ifdef ID_FORWARD_EN
      sb_ld_q[0] <= out_ld_q;
`endif
      for (int unsigned k = WB_DEPTH - 1; k > 0; k--) begin
        sb_v_q[k]  <= sb_v_q[k-1];
        sb_rd_q[k] <= sb_rd_q[k-1];
`ifdef ID_FORWARD_EN
        sb_ld_q[k] <= sb_ld_q[k-1];
`endif
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_opcode   = out_opcode_q;
  assign out_func3    = out_func3_q;
  assign out_func7b5  = out_f7_q;
  assign out_rs1      = out_rs1_q;
  assign out_rs2      = out_rs2_q;
  assign out_rd       = out_rd_q;
  assign out_regwrite = out_rw_q;
  assign out_imm      = out_imm_q;
  assign out_illegal  = out_ill_q;

endmodule

// File: tb/tb_id_hazard_stage.sv
// tb_id_hazard_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the decode stage and its write-back window.
module tb_id_hazard_stage;

  localparam int unsigned WB = 3;
`ifdef ID_FORWARD_EN
  localparam int EXP_RAW = 0;
  localparam int EXP_LU  = 2;
`else
  localparam int EXP_RAW = 4;
  localparam int EXP_LU  = 4;
`endif

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_func3;
  logic        out_func7b5, out_regwrite, out_illegal, stall;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  always #5 clk = ~clk;

  id_hazard_stage #(.XLEN(32), .REGW(5), .WB_DEPTH(WB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_func3(out_func3), .out_func7b5(out_func7b5), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_imm(out_imm), .out_illegal(out_illegal), .stall(stall)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] imm;
    logic        ill;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: output entry plus a list of committed-pending writes tagged with their age
  bit         m_ov;
  ent_t       m_ent;
  bit         m_ld;
  int         p_age[$];
  logic [4:0] p_rd[$];
  bit         p_ld[$];

  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    bit u1, u2, wr;
    int imm;
    e = '0; u1 = 0; u2 = 0; wr = 0; imm = 0;
    e.pc = pc; e.opc = ins[6:0]; e.f3 = ins[14:12]; e.f7 = ins[30];
    case (ins[6:0])
      7'h33: begin u1 = 1; u2 = 1; wr = 1; end
      7'h13, 7'h03, 7'h67: begin
        u1 = 1; wr = 1;
        imm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
      end
      7'h23: begin
        u1 = 1; u2 = 1;
        imm = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
      end
      7'h63: begin
        u1 = 1; u2 = 1;
        imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2;
      end
      7'h37, 7'h17: begin wr = 1; imm = int'(ins & 32'hFFFF_F000); end
      7'h6F: begin
        wr = 1;
        imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
              + int'(ins[30:21]) * 2;
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = imm;
    e.rs1 = u1 ? ins[19:15] : 5'd0;
    e.rs2 = u2 ? ins[24:20] : 5'd0;
    e.rw  = wr && (ins[11:7] != 5'd0);
    e.rd  = e.rw ? ins[11:7] : 5'd0;
    return e;
  endfunction

  function automatic bit ref_hazard(input logic [31:0] ins);
    ent_t d;
    logic [4:0] rs[2];
    d = ref_decode(ins, 32'd0);
    rs[0] = d.rs1; rs[1] = d.rs2;
    for (int i = 0; i < 2; i++) begin
      if (rs[i] == 5'd0) continue;
`ifdef ID_FORWARD_EN
      if (m_ov && m_ent.rw && m_ld && m_ent.rd == rs[i]) return 1;
      foreach (p_age[j]) if (p_age[j] == 0 && p_ld[j] && p_rd[j] == rs[i]) return 1;
`else
      if (m_ov && m_ent.rw && m_ent.rd == rs[i]) return 1;
      foreach (p_rd[j]) if (p_rd[j] == rs[i]) return 1;
`endif
    end
    return 0;
  endfunction

  function automatic ent_t observe();
    ent_t o;
    o.pc = out_pc; o.opc = out_opcode; o.f3 = out_func3; o.f7 = out_func7b5;
    o.rs1 = out_rs1; o.rs2 = out_rs2; o.rd = out_rd; o.rw = out_regwrite;
    o.imm = out_imm; o.ill = out_illegal;
    return o;
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  // One clock: sample handshake at negedge, advance model at posedge, return at posedge+1
  task automatic tick(output bit o_rdy, output bit o_stall, output bit e_rdy, output bit e_stall);
    bit acc, xfer, nld;
    ent_t nd;
    int na[$];
    logic [4:0] nr[$];
    bit nl[$];
    @(negedge clk);
    o_rdy = in_ready; o_stall = stall;
    e_stall = in_valid && ref_hazard(in_instr);
    e_rdy = !flush && !e_stall && (!m_ov || out_ready);
    acc  = in_valid && e_rdy;
    xfer = m_ov && out_ready && !flush;
    nd   = ref_decode(in_instr, in_pc);
    nld  = (in_instr[6:0] == 7'h03);
    @(posedge clk);
    foreach (p_age[j]) begin
      if (p_age[j] + 1 < int'(WB)) begin
        na.push_back(p_age[j] + 1); nr.push_back(p_rd[j]); nl.push_back(p_ld[j]);
      end
    end
    if (xfer && m_ent.rw) begin
      na.push_back(0); nr.push_back(m_ent.rd); nl.push_back(m_ld);
    end
    p_age = na; p_rd = nr; p_ld = nl;
    if (flush) m_ov = 0;
    else if (acc) begin m_ov = 1; m_ent = nd; m_ld = nld; end
    else if (out_ready) m_ov = 0;
    #1;
  endtask

  task automatic idle(input int n);
    bit a, b, c, d;
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (n) tick(a, b, c, d);
  endtask

  // Present one instruction until accepted; report stall cycles and model agreement
  task automatic issue(input logic [31:0] ins, output int stalls, output bit agree, output bit ok);
    bit ordy, ost, erdy, est;
    in_valid = 1; in_instr = ins; in_pc = $urandom;
    stalls = 0; agree = 1; ok = 0;
    for (int c = 0; c < 20; c++) begin
      tick(ordy, ost, erdy, est);
      if (ordy !== erdy || ost !== est) agree = 0;
      if (ost) stalls++;
      if (ordy) begin ok = 1; break; end
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    bit ordy, ost, erdy, est;
    reset = 0; in_valid = 1; flush = 0; out_ready = 1;
    in_instr = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5); in_pc = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (observe() !== '0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", observe()); end
    m_ov = 0; m_ent = '0; m_ld = 0; p_age.delete(); p_rd.delete(); p_ld.delete();
    in_valid = 0; reset = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    in_valid = 1;
    tick(ordy, ost, erdy, est);
    in_valid = 0;
    n_checks++;
    if (!(ordy === 1'b1 && out_valid === 1'b1 && observe() === m_ent && out_rd === 5'd1)) begin
      n_fail++; $display("FAIL first_issue got rdy=%b v=%b rd=%0d exp rdy=1 v=1 rd=1", ordy, out_valid, out_rd);
    end
  endtask

  task automatic test_raw_stall();
    int st; bit ag, ok;
    idle(WB + 2);
    issue(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5), st, ag, ok);
    issue(enc_r(5'd2, 5'd1, 5'd1), st, ag, ok);
    n_checks++;
    if (!ok || !ag) begin n_fail++; $display("FAIL raw_handshake got ok=%b agree=%b exp 1 1", ok, ag); end
    n_checks++;
    if (st !== EXP_RAW) begin n_fail++; $display("FAIL raw_stalls got=%0d exp=%0d", st, EXP_RAW); end
    n_checks++;
    if (!(out_valid === 1'b1 && out_rs1 === 5'd1 && out_rs2 === 5'd1 && out_rd === 5'd2 && out_regwrite === 1'b1)) begin
      n_fail++; $display("FAIL raw_issue got rs1=%0d rs2=%0d rd=%0d exp 1 1 2", out_rs1, out_rs2, out_rd);
    end
  endtask

  task automatic test_x0();
    int st; bit ag, ok;
    idle(WB + 2);
    issue(enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd1), st, ag, ok);
    n_checks++;
    if (!(ok && out_regwrite === 1'b0 && out_rd === 5'd0)) begin
      n_fail++; $display("FAIL x0_write got rw=%b rd=%0d exp rw=0 rd=0", out_regwrite, out_rd);
    end
    issue(enc_r(5'd2, 5'd0, 5'd0), st, ag, ok);
    n_checks++;
    if (!(ok && ag && st == 0)) begin n_fail++; $display("FAIL x0_stall got=%0d exp=0", st); end
  endtask

  task automatic test_load_use();
    int st; bit ag, ok;
    idle(WB + 2);
    issue(enc_i(7'h03, 3'd2, 5'd3, 5'd1, 12'd0), st, ag, ok);
    issue(enc_r(5'd4, 5'd3, 5'd0), st, ag, ok);
    n_checks++;
    if (!(ok && ag && st == EXP_LU)) begin n_fail++; $display("FAIL load_use got=%0d exp=%0d", st, EXP_LU); end
    idle(WB + 2);
    issue(enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'd1), st, ag, ok);
    issue(enc_r(5'd6, 5'd5, 5'd5), st, ag, ok);
    n_checks++;
    if (!(ok && ag && st == EXP_RAW)) begin n_fail++; $display("FAIL alu_use got=%0d exp=%0d", st, EXP_RAW); end
  endtask

  task automatic test_backpressure();
    int st; bit ag, ok, ordy, ost, erdy, est;
    ent_t snap;
    idle(WB + 2);
    issue({7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'h23}, st, ag, ok);
    snap = observe();
    out_ready = 0; in_valid = 1; in_instr = enc_i(7'h13, 3'd0, 5'd9, 5'd0, 12'd3);
    for (int c = 0; c < 3; c++) begin
      tick(ordy, ost, erdy, est);
      n_checks++;
      if (!(ordy === 1'b0 && out_valid === 1'b1 && observe() === snap)) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b out=%h exp rdy=0 v=1 out=%h", c, ordy, out_valid, observe(), snap);
      end
    end
    n_checks++;
    if (!(out_imm === 32'hFFFF_FFFC && out_regwrite === 1'b0 && out_rs1 === 5'd1 && out_rs2 === 5'd2)) begin
      n_fail++; $display("FAIL sw_decode got imm=%h rw=%b exp imm=fffffffc rw=0", out_imm, out_regwrite);
    end
    out_ready = 1;
    issue(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd7), st, ag, ok);
    issue(32'h0020_8F7F, st, ag, ok);
    n_checks++;
    if (!(ok && ag && st == 0 && out_illegal === 1'b1 && out_regwrite === 1'b0 && out_rs1 === 5'd0 && out_rs2 === 5'd0)) begin
      n_fail++; $display("FAIL illegal got st=%0d ill=%b rw=%b rs1=%0d exp st=0 ill=1 rw=0 rs1=0", st, out_illegal, out_regwrite, out_rs1);
    end
  endtask

  task automatic test_flush();
    int st; bit ag, ok, ordy, ost, erdy, est;
    idle(WB + 2);
    issue(enc_i(7'h13, 3'd0, 5'd7, 5'd0, 12'd1), st, ag, ok);
    out_ready = 0; flush = 1; in_valid = 1; in_instr = enc_r(5'd8, 5'd7, 5'd7);
    tick(ordy, ost, erdy, est);
    flush = 0; in_valid = 0; out_ready = 1;
    n_checks++;
    if (!(ordy === 1'b0 && out_valid === 1'b0)) begin
      n_fail++; $display("FAIL flush_kill got rdy=%b v=%b exp rdy=0 v=0", ordy, out_valid);
    end
    issue(enc_r(5'd8, 5'd7, 5'd7), st, ag, ok);
    n_checks++;
    if (!(ok && ag && st == 0 && out_rs1 === 5'd7 && out_rd === 5'd8)) begin
      n_fail++; $display("FAIL flush_after got st=%0d rs1=%0d rd=%0d exp 0 7 8", st, out_rs1, out_rd);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F};
    logic [31:0] ins;
    bit ordy, ost, erdy, est;
    idle(WB + 2);
    for (int c = 0; c < 400; c++) begin
      ins = $urandom;
      ins[6:0]   = opcs[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      in_instr  = ins;
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick(ordy, ost, erdy, est);
      n_checks++;
      if (ordy !== erdy || ost !== est) begin
        n_fail++; $display("FAIL rnd_hs cyc=%0d got rdy=%b stall=%b exp rdy=%b stall=%b", c, ordy, ost, erdy, est);
      end
      n_checks++;
      if (out_valid !== m_ov) begin
        n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, m_ov);
      end
      if (m_ov) begin
        n_checks++;
        if (observe() !== m_ent) begin
          n_fail++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", c, observe(), m_ent);
        end
      end
    end
    flush = 0; in_valid = 0; out_ready = 1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0; in_valid = 0; flush = 0; out_ready = 1; in_instr = '0; in_pc = '0;
    test_reset();
    test_raw_stall();
    test_x0();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
